// File: rtl/bus_slave_resp_mux.sv
// Registered slave-to-master response mux: latches the winning chip-select for the whole transaction.
// Optional timeout counter is built only when BUS_TIMEOUT_EN is defined.
module bus_slave_resp_mux #(
    parameter int NUM_SLAVES     = 8,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255,
    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
    input  logic                         clk,
    input  logic                         reset_,
    input  logic [NUM_SLAVES-1:0]        s_cs_,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_rd_data,
    input  logic [NUM_SLAVES-1:0]        s_rdy_,
    output logic [DATA_W-1:0]            m_rd_data,
    output logic                         m_rdy_,
    output logic                         m_err,
    output logic                         busy,
    output logic [IDX_W-1:0]             sel_idx
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    state_t                  state;
    logic                    multi;
    logic [DATA_W-1:0]       slice [NUM_SLAVES];
    logic [IDX_W-1:0]        pick;
    logic [NUM_SLAVES-1:0]   cs_vec;
    logic                    any_cs;
    logic                    multi_now;

    for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_slice
        assign slice[g] = s_rd_data[g*DATA_W +: DATA_W];
    end

    // Fixed priority: the lowest-index active chip-select wins.
    always_comb begin
        pick = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (!s_cs_[i]) pick = IDX_W'(i);
        end
    end

    assign cs_vec    = ~s_cs_;
    assign any_cs    = |cs_vec;
    assign multi_now = |(cs_vec & (cs_vec - NUM_SLAVES'(1)));
    assign busy      = (state != ST_IDLE);

`ifdef BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             timed_out;

    // Saturating increment; the WAIT exit happens when the count hits the limit.
    assign cnt_next  = (cnt == CNT_W'(TIMEOUT_CYCLES)) ? cnt : cnt + 1'b1;
    assign timed_out = (cnt_next == CNT_W'(TIMEOUT_CYCLES));
`endif

    always_ff @(posedge clk) begin
        if (!reset_) begin
            state     <= ST_IDLE;
            m_rdy_    <= 1'b1;
            m_err     <= 1'b0;
            m_rd_data <= '0;
            sel_idx   <= '0;
            multi     <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            cnt       <= '0;
`endif
        end else begin
            m_rdy_ <= 1'b1;
            m_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any_cs) begin
                        sel_idx <= pick;
                        multi   <= multi_now;
                        if (!s_rdy_[pick]) begin
                            m_rd_data <= slice[pick];
                            m_rdy_    <= 1'b0;
                            m_err     <= multi_now;
                            state     <= ST_RESP;
                        end else begin
`ifdef BUS_TIMEOUT_EN
                            cnt   <= '0;
`endif
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    // Abort beats ready, ready beats timeout.
                    if (s_cs_[sel_idx]) begin
                        state <= ST_IDLE;
                    end else if (!s_rdy_[sel_idx]) begin
                        m_rd_data <= slice[sel_idx];
                        m_rdy_    <= 1'b0;
                        m_err     <= multi;
                        state     <= ST_RESP;
`ifdef BUS_TIMEOUT_EN
                    end else if (timed_out) begin
                        m_rd_data <= '0;
                        m_rdy_    <= 1'b0;
                        m_err     <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        cnt <= cnt_next;
`endif
                    end
                end
                ST_RESP: begin
                    state <= any_cs ? ST_HOLD : ST_IDLE;
                end
                ST_HOLD: begin
                    if (!any_cs) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_slave_resp_mux.sv
// Bench for bus_slave_resp_mux: directed steps then random transactions against a transaction-level model.
module tb_bus_slave_resp_mux;
    localparam int N = 8;
    localparam int W = 32;
    localparam int T = 4;

`ifdef BUS_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset_;
    logic [N-1:0]     s_cs_;
    logic [N*W-1:0]   s_rd_data;
    logic [N-1:0]     s_rdy_;
    logic [W-1:0]     m_rd_data;
    logic             m_rdy_;
    logic             m_err;
    logic             busy;
    logic [2:0]       sel_idx;

    int total = 0;
    int bad   = 0;

    bus_slave_resp_mux #(
        .NUM_SLAVES(N), .DATA_W(W), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk), .reset_(reset_), .s_cs_(s_cs_), .s_rd_data(s_rd_data),
        .s_rdy_(s_rdy_), .m_rd_data(m_rd_data), .m_rdy_(m_rdy_),
        .m_err(m_err), .busy(busy), .sel_idx(sel_idx)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit expired, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_data(input int idx, input logic [W-1:0] d);
        s_rd_data[idx*W +: W] = d;
    endtask

    task automatic noise_data();
        for (int i = 0; i < N; i++) set_data(i, $urandom);
    endtask

    task automatic chk_idle(input string tag, input logic [W-1:0] exp_data);
        chk({tag, "_rdy"}, 64'(m_rdy_), 64'd1);
        chk({tag, "_err"}, 64'(m_err), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_data"}, 64'(m_rd_data), 64'(exp_data));
    endtask

    task automatic chk_resp(input string tag, input logic [W-1:0] d, input logic e, input int s);
        chk({tag, "_rdy"}, 64'(m_rdy_), 64'd0);
        chk({tag, "_data"}, 64'(m_rd_data), 64'(d));
        chk({tag, "_err"}, 64'(m_err), 64'(e));
        chk({tag, "_sel"}, 64'(sel_idx), 64'(s));
    endtask

    initial begin
        logic [W-1:0] last_data;
        int           pulses;
        int           busy_drops;

        // Reset and idle
        reset_ = 1'b0;
        s_cs_  = '1;
        s_rdy_ = '1;
        noise_data();
        tick();
        tick();
        chk_idle("reset", '0);
        chk("reset_sel", 64'(sel_idx), 64'd0);
        reset_ = 1'b1;
        tick();
        tick();
        chk_idle("idle", '0);

        // Zero-wait read on slave 3, cs held two more cycles
        s_cs_  = ~(8'(1) << 3);
        s_rdy_ = ~(8'(1) << 3);
        set_data(3, 32'hDEADBEEF);
        tick();
        chk_resp("zw", 32'hDEADBEEF, 1'b0, 3);
        s_rdy_ = '1;
        noise_data();
        tick();
        chk("zw_hold1_rdy", 64'(m_rdy_), 64'd1);
        chk("zw_hold1_busy", 64'(busy), 64'd1);
        chk("zw_hold1_data", 64'(m_rd_data), 64'hDEADBEEF);
        s_rdy_ = ~(8'(1) << 3);
        tick();
        chk("zw_hold2_rdy", 64'(m_rdy_), 64'd1);
        s_cs_  = '1;
        s_rdy_ = '1;
        tick();
        chk_idle("zw_end", 32'hDEADBEEF);

        // Selection lock: slave 5 latched, slave 1 arrives later and is ignored;
        // slave 5 ready lands on the timeout edge as well, ready must win
        s_cs_ = ~(8'(1) << 5);
        tick();
        chk("lock_busy", 64'(busy), 64'd1);
        chk("lock_sel", 64'(sel_idx), 64'd5);
        tick();
        chk("lock_w1_rdy", 64'(m_rdy_), 64'd1);
        s_cs_ = ~((8'(1) << 5) | (8'(1) << 1));
        tick();
        chk("lock_w2_rdy", 64'(m_rdy_), 64'd1);
        s_rdy_ = ~(8'(1) << 1);
        set_data(1, 32'h11111111);
        tick();
        chk("lock_w3_rdy", 64'(m_rdy_), 64'd1);
        s_rdy_ = ~(8'(1) << 5);
        set_data(5, 32'h5555AAAA);
        tick();
        chk_resp("lock", 32'h5555AAAA, 1'b0, 5);
        s_cs_  = '1;
        s_rdy_ = '1;
        tick();
        chk_idle("lock_end", 32'h5555AAAA);

        // Multi-select
        s_cs_  = ~8'b0000_0101;
        s_rdy_ = ~8'b0000_0001;
        set_data(0, 32'h12345678);
        tick();
        chk_resp("multi", 32'h12345678, 1'b1, 0);
        s_cs_  = '1;
        s_rdy_ = '1;
        tick();
        chk_idle("multi_end", 32'h12345678);

        // Timeout on slave 6
        s_cs_ = ~(8'(1) << 6);
        tick();
        if (TO_EN) begin
            for (int k = 1; k < T; k++) begin
                tick();
                chk("to_wait_rdy", 64'(m_rdy_), 64'd1);
            end
            tick();
            chk_resp("to", '0, 1'b1, 6);
            last_data = '0;
        end else begin
            pulses = 0;
            busy_drops = 0;
            for (int k = 0; k < 1000; k++) begin
                tick();
                if (!m_rdy_) pulses++;
                if (!busy) busy_drops++;
            end
            chk("noto_pulses", 64'(pulses), 64'd0);
            chk("noto_busy_drops", 64'(busy_drops), 64'd0);
            last_data = 32'h12345678;
        end
        s_cs_ = '1;
        tick();
        chk_idle("to_end", last_data);

        // Abort in WAIT with ready on the same edge
        s_cs_ = ~(8'(1) << 2);
        tick();
        chk("abort_busy", 64'(busy), 64'd1);
        tick();
        s_cs_  = '1;
        s_rdy_ = ~(8'(1) << 2);
        tick();
        chk_idle("abort", last_data);
        s_rdy_ = '1;
        tick();
        chk_idle("abort_after", last_data);

        // Reset while in WAIT
        s_cs_ = ~(8'(1) << 4);
        tick();
        chk("rstw_busy", 64'(busy), 64'd1);
        reset_ = 1'b0;
        tick();
        chk_idle("rstw", '0);
        chk("rstw_sel", 64'(sel_idx), 64'd0);
        reset_ = 1'b1;
        s_cs_  = '1;
        tick();
        chk_idle("rstw_after", '0);
        last_data = '0;

        // Random transactions against a transaction-level model
        for (int n = 0; n < 150; n++) begin
            logic [N-1:0] mask;
            logic [W-1:0] d;
            int  sel, w, r, a, h;
            bit  multi, tmo, abort, done;
            mask  = N'($urandom_range(1, (1 << N) - 1));
            sel   = 0;
            while (!mask[sel]) sel++;
            multi = ($countones(mask) > 1);
            w     = $urandom_range(0, 6);
            tmo   = TO_EN && (w > T);
            r     = tmo ? T : w;
            abort = 1'b0;
            a     = -1;
            if ($urandom_range(0, 4) == 0) begin
                if (!tmo && r >= 1) begin
                    abort = 1'b1;
                    a = $urandom_range(1, r);
                end else if (tmo && r >= 2) begin
                    abort = 1'b1;
                    a = $urandom_range(1, r - 1);
                end
            end
            d    = $urandom;
            done = 1'b0;
            for (int k = 0; k <= r && !done; k++) begin
                if (k == 0) s_cs_ = ~mask;
                else begin
                    s_cs_ = N'($urandom);
                    s_cs_[sel] = 1'b0;
                end
                if (abort && k == a) s_cs_ = '1;
                s_rdy_ = N'($urandom);
                s_rdy_[sel] = (k == w) ? 1'b0 : 1'b1;
                noise_data();
                if (k == w) set_data(sel, d);
                tick();
                if (abort && k == a) begin
                    chk_idle("rnd_abort", last_data);
                    done = 1'b1;
                end else if (k < r) begin
                    chk("rnd_wait_rdy", 64'(m_rdy_), 64'd1);
                    chk("rnd_wait_busy", 64'(busy), 64'd1);
                end else begin
                    last_data = tmo ? '0 : d;
                    chk_resp("rnd_resp", last_data, tmo | multi, sel);
                end
            end
            if (!done) begin
                h = $urandom_range(0, 2);
                for (int k = 0; k < h; k++) begin
                    s_cs_  = ~mask;
                    s_rdy_ = N'($urandom);
                    noise_data();
                    tick();
                    chk("rnd_hold_rdy", 64'(m_rdy_), 64'd1);
                    chk("rnd_hold_busy", 64'(busy), 64'd1);
                    chk("rnd_hold_data", 64'(m_rd_data), 64'(last_data));
                end
            end
            s_cs_  = '1;
            s_rdy_ = N'($urandom);
            tick();
            chk_idle("rnd_end", last_data);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
